uart_pkt_dispatch: RTL and testbench
====================================

// Module: uart_pkt_dispatch
// PURPOSE
//  Sits between the UART byte receiver and the DC-channel / launch register files inside uart_api_dc.
//  Assembles received bytes MSB-first into 32-bit words and decodes a header word, which selects:
//  - a DC channel packet (one channel), or
//  - a launch packet.
//  Streams the body words out as indexed register writes, and resyncs on bad headers or inter-byte timeout.
// PARAMETERS
//  DAC_CHANNEL     4     number of DC channels; header bits [8 +: DAC_CHANNEL] select a channel
//  DC_REGS         8     32-bit body words per DC packet (DEPTH*3+2)
//  LAUNCH_REGS     4     32-bit body words per launch packet
//  TIMEOUT_CYCLES  8192  idle clocks mid-packet before abort (>= 2 byte times at 921600 baud / 100 MHz)
// PORTS
//  i_clk         in   1            system clock
//  i_rst         in   1            synchronous active-high reset
//  i_rx_data     in   8            received byte, valid when i_rx_valid
//  i_rx_valid    in   1            one-cycle strobe per received byte
//  o_wr_en       out  1            one-cycle write strobe for o_wr_data
//  o_wr_dc_sel   out  DAC_CHANNEL  one-hot target channel (all zero for launch writes)
//  o_wr_launch   out  1            target is the launch register file
//  o_wr_addr     out  $clog2(max(DC_REGS,LAUNCH_REGS))  word index within packet, 0-based
//  o_wr_data     out  32           assembled word, first received byte in [31:24]
//  o_pkt_done    out  1            one-cycle pulse, coincident with the last body write
//  o_pkt_err     out  1            one-cycle pulse on bad header or timeout
// BEHAVIOUR
//  Reset: all outputs 0. State is HDR; byte count, word count and timeout counter are 0; shift register is 0.
//  Byte assembly:
//  - Each i_rx_valid shifts i_rx_data in: sh <= {sh[23:0], i_rx_data}; byte count increments mod 4.
//  - A word completes on the 4th byte. Decode and write happen the following cycle, so latency is 1 clock from the 4th strobe.
//  States: HDR, DC_BODY, LAUNCH_BODY.
//  HDR, on word complete, with inv = ~word:
//  - inv == 0 -> LAUNCH_BODY.
//  - inv is one-hot at bit 8+i with i < DAC_CHANNEL -> DC_BODY, latch sel = 1<<i.
//  - otherwise -> o_pkt_err for 1 cycle, stay in HDR.
//  - No write is issued for a header word.
//  Body writes:
//  - Each completed word emits o_wr_en=1 with o_wr_addr = word count, o_wr_data = word, and o_wr_dc_sel / o_wr_launch per the latched target. The word count then increments.
//  - The last word (index DC_REGS-1 or LAUNCH_REGS-1) also pulses o_pkt_done. The FSM returns to HDR and the word count clears.
//  - o_wr_dc_sel, o_wr_launch, o_wr_addr and o_wr_data are held between strobes. Consumers sample only when o_wr_en=1.
//  Consecutive packets: a header byte may arrive on the very cycle after the last body byte; no bytes are lost.
//  Timeout:
//  - The counter runs whenever state != HDR or byte count != 0. It clears on every i_rx_valid.
//  - On reaching TIMEOUT_CYCLES-1: pulse o_pkt_err, discard the partial word and packet, go to HDR, zero the counts.
//  - Writes already issued are not retracted.
//  Simultaneous events: an i_rx_valid on the timeout cycle wins. The counter clears and the byte is accepted.
//  Reset mid-packet: every state returns to reset values; no o_wr_en or o_pkt_done is emitted for the partial packet.
//  No backpressure: consumers accept one write per cycle. Writes arrive at most every 4 byte times.
// TESTING
//  1. DC ch0: bytes FF FF FE FF, then 8 words 00000001..00000008
//     -> 8 o_wr_en, sel=0001, addr 0..7, data matches; o_pkt_done with addr 7; no err.
//  2. DC ch3 header FF FF F7 FF, then launch header FF FF FF FF + 4 words
//     -> 8 writes sel=1000, then 4 writes o_wr_launch=1 addr 0..3 with the last pulsing done.
//  3. Bad header FF FF FC FF (two bits clear), or FF FF EF FF (channel 4 with DAC_CHANNEL=4)
//     -> o_pkt_err 1 cycle, no writes; a following valid ch1 packet decodes correctly.
//  4. ch2 header + 2.5 words, then silence
//     -> 2 writes, o_pkt_err exactly TIMEOUT_CYCLES after the last byte; next packet is clean.
//  5. i_rst asserted after 5 body words of a ch0 packet
//     -> outputs 0 next cycle, no done; a fresh packet is written from addr 0.
//  6. Back-to-back bytes on consecutive clocks, and a byte strobe coinciding with the timeout cycle
//     -> all bytes assembled, no err.

Source files
------------

// File: rtl/uart_pkt_dispatch.sv
// ---------------------------------------------------------------------------
// uart_pkt_dispatch
//
// Packs bytes from the UART receiver into 32-bit words, first byte in the MSB.
// The first word of each packet is a header. Its bitwise inverse selects the
// packet type:
//   - all zero                     : launch packet
//   - a single one at bit 8+i      : DC channel i packet
//   - anything else                : bad header (o_pkt_err, stay in HDR)
// Every body word after the header is emitted as an indexed register write.
// A stall in the middle of a packet or of a word aborts the packet and
// resynchronises to a header.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_rx_data    received byte, valid while i_rx_valid is high
//   i_rx_valid   one-cycle strobe per received byte
//   o_wr_en      one-cycle write strobe
//   o_wr_dc_sel  one-hot DC channel target (zero for launch writes)
//   o_wr_launch  target is the launch register file
//   o_wr_addr    word index within the packet, 0-based
//   o_wr_data    assembled body word
//   o_pkt_done   pulse coincident with the last body write
//   o_pkt_err    pulse on bad header or timeout
// ---------------------------------------------------------------------------
module uart_pkt_dispatch #(
  parameter int DAC_CHANNEL    = 4,
  parameter int DC_REGS        = 8,
  parameter int LAUNCH_REGS    = 4,
  parameter int TIMEOUT_CYCLES = 8192,
  localparam int MAX_REGS = (DC_REGS > LAUNCH_REGS) ? DC_REGS : LAUNCH_REGS,
  localparam int AW       = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_wr_en,
  output logic [DAC_CHANNEL-1:0] o_wr_dc_sel,
  output logic                   o_wr_launch,
  output logic [AW-1:0]          o_wr_addr,
  output logic [31:0]            o_wr_data,
  output logic                   o_pkt_done,
  output logic                   o_pkt_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    HDR,
    DC_BODY,
    LAUNCH_BODY
  } state_t;

  state_t                 state;
  state_t                 state_next;
  // Only the three most recent bytes need storing; the fourth byte is taken
  // straight from i_rx_data when a word completes.
  logic [23:0]            sh;
  logic [1:0]             byte_cnt;
  logic [AW-1:0]          word_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [DAC_CHANNEL-1:0] sel;

  logic [31:0]            word;
  logic [31:0]            inv;
  logic                   word_complete;
  logic                   tmo_active;
  logic                   tmo_hit;
  logic                   hdr_launch;
  logic                   hdr_dc;
  logic [DAC_CHANNEL-1:0] hdr_sel;
  logic                   last_word;

  logic                   wr_en_nx;
  logic                   done_nx;
  logic                   err_nx;

  assign word          = {sh, i_rx_data};
  assign inv           = ~word;
  assign word_complete = i_rx_valid && (byte_cnt == 2'd3);
  assign tmo_active    = (state != HDR) || (byte_cnt != 2'd0);
  // A byte arriving on the timeout cycle takes priority and restarts the count.
  assign tmo_hit       = tmo_active && !i_rx_valid &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign hdr_launch    = (inv == 32'd0);
  assign last_word     = ((state == DC_BODY)     && (word_cnt == AW'(DC_REGS - 1))) ||
                         ((state == LAUNCH_BODY) && (word_cnt == AW'(LAUNCH_REGS - 1)));

  // Header decode: the inverted header must be exactly one-hot at bit 8+i.
  always_comb begin
    hdr_dc  = 1'b0;
    hdr_sel = '0;
    for (int i = 0; i < DAC_CHANNEL; i++) begin
      if (inv == (32'd1 << (8 + i))) begin
        hdr_dc     = 1'b1;
        hdr_sel[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (tmo_hit) begin
      state_next = HDR;
    end else if (word_complete) begin
      case (state)
        HDR: begin
          if (hdr_launch) begin
            state_next = LAUNCH_BODY;
          end else if (hdr_dc) begin
            state_next = DC_BODY;
          end
        end
        DC_BODY, LAUNCH_BODY: begin
          if (last_word) begin
            state_next = HDR;
          end
        end
        default: state_next = HDR;
      endcase
    end
  end

  // Output decode: the values the output strobes take after this clock edge
  always_comb begin
    wr_en_nx = word_complete && (state != HDR);
    done_nx  = wr_en_nx && last_word;
    err_nx   = tmo_hit ||
               (word_complete && (state == HDR) && !hdr_launch && !hdr_dc);
  end

  // Datapath: byte assembly, word/timeout counters, latched target and the
  // registered write port. Address, data and target hold between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh          <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      tmo_cnt     <= '0;
      sel         <= '0;
      o_wr_en     <= 1'b0;
      o_wr_dc_sel <= '0;
      o_wr_launch <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_pkt_done  <= 1'b0;
      o_pkt_err   <= 1'b0;
    end else begin
      o_wr_en    <= wr_en_nx;
      o_pkt_done <= done_nx;
      o_pkt_err  <= err_nx;

      if (tmo_hit) begin
        sh       <= '0;
        byte_cnt <= '0;
        word_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        if (i_rx_valid) begin
          sh       <= word[23:0];
          byte_cnt <= byte_cnt + 2'd1;
          tmo_cnt  <= '0;
        end else if (tmo_active) begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
          tmo_cnt <= '0;
        end

        if (wr_en_nx) begin
          word_cnt <= last_word ? '0 : word_cnt + AW'(1);
        end
      end

      if (word_complete && (state == HDR) && hdr_dc) begin
        sel <= hdr_sel;
      end

      if (wr_en_nx) begin
        o_wr_addr   <= word_cnt;
        o_wr_data   <= word;
        o_wr_dc_sel <= (state == DC_BODY) ? sel : '0;
        o_wr_launch <= (state == LAUNCH_BODY);
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_dispatch.sv
// ---------------------------------------------------------------------------
// tb_uart_pkt_dispatch
//
// Directed bench for uart_pkt_dispatch. A free-running monitor logs every
// write strobe, done pulse and error pulse; each scenario task drives bytes
// and compares the log against hand-computed packets.
// ---------------------------------------------------------------------------
module tb_uart_pkt_dispatch;

  localparam int NCH  = 4;
  localparam int DCR  = 8;
  localparam int LR   = 4;
  localparam int TMO  = 8192;
  localparam int AW   = 3;

  typedef struct packed {
    logic [NCH-1:0] sel;
    logic           launch;
    logic [AW-1:0]  addr;
    logic [31:0]    data;
    logic           done;
  } wr_t;

  logic           clk;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           wr_en;
  logic [NCH-1:0] wr_dc_sel;
  logic           wr_launch;
  logic [AW-1:0]  wr_addr;
  logic [31:0]    wr_data;
  logic           pkt_done;
  logic           pkt_err;

  int  total;
  int  bad;
  int  cyc;
  int  err_cnt;
  int  err_cyc;
  int  done_cnt;
  wr_t wrq[$];

  uart_pkt_dispatch #(
    .DAC_CHANNEL    (NCH),
    .DC_REGS        (DCR),
    .LAUNCH_REGS    (LR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_wr_en     (wr_en),
    .o_wr_dc_sel (wr_dc_sel),
    .o_wr_launch (wr_launch),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_pkt_done  (pkt_done),
    .o_pkt_err   (pkt_err)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time the error pulse
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor sampling on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (wr_en) wrq.push_back('{wr_dc_sel, wr_launch, wr_addr, wr_data, pkt_done});
    if (pkt_done) done_cnt <= done_cnt + 1;
    if (pkt_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) begin
      put_byte(w[8*k +: 8]);
      idle(gap);
    end
  endtask

  task automatic clear_log();
    idle(3);
    wrq.delete();
    err_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);
    total++;
    if ({wr_en, wr_dc_sel, wr_launch, wr_addr, wr_data, pkt_done, pkt_err} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got en=%b sel=%b l=%b a=%0d d=%h done=%b err=%b want all 0",
               wr_en, wr_dc_sel, wr_launch, wr_addr, wr_data, pkt_done, pkt_err);
    end
  endtask

  task automatic test_dc_ch0();
    clear_log();
    put_word(32'hFFFF_FEFF, 1);
    for (int i = 0; i < DCR; i++) put_word(32'(i + 1), 1);
    idle(4);
    total++;
    if (wrq.size() != DCR) begin
      bad++; $display("[TB] FAIL dc0_count got %0d want %0d", wrq.size(), DCR);
    end
    for (int i = 0; i < wrq.size() && i < DCR; i++) begin
      total++;
      if (wrq[i] !== wr_t'{4'b0001, 1'b0, AW'(i), 32'(i + 1), (i == DCR - 1)}) begin
        bad++; $display("[TB] FAIL dc0_write%0d got %h want %h", i, wrq[i],
                        wr_t'{4'b0001, 1'b0, AW'(i), 32'(i + 1), (i == DCR - 1)});
      end
    end
    total++;
    if (err_cnt != 0 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL dc0_flags got err=%0d done=%0d want err=0 done=1", err_cnt, done_cnt);
    end
  endtask

  task automatic test_dc3_launch();
    clear_log();
    put_word(32'hFFFF_F7FF, 0);
    for (int i = 0; i < DCR; i++) put_word(32'hA500_0000 + 32'(i), 0);
    put_word(32'hFFFF_FFFF, 0);
    for (int i = 0; i < LR; i++) put_word(32'hC0DE_0000 + 32'(i), 0);
    idle(4);
    total++;
    if (wrq.size() != DCR + LR) begin
      bad++; $display("[TB] FAIL dc3l_count got %0d want %0d", wrq.size(), DCR + LR);
    end
    for (int i = 0; i < wrq.size() && i < DCR + LR; i++) begin
      wr_t exp;
      if (i < DCR) exp = '{4'b1000, 1'b0, AW'(i), 32'hA500_0000 + 32'(i), (i == DCR - 1)};
      else         exp = '{4'b0000, 1'b1, AW'(i - DCR), 32'hC0DE_0000 + 32'(i - DCR), (i == DCR + LR - 1)};
      total++;
      if (wrq[i] !== exp) begin
        bad++; $display("[TB] FAIL dc3l_write%0d got %h want %h", i, wrq[i], exp);
      end
    end
    total++;
    if (err_cnt != 0 || done_cnt != 2) begin
      bad++; $display("[TB] FAIL dc3l_flags got err=%0d done=%0d want err=0 done=2", err_cnt, done_cnt);
    end
  endtask

  task automatic test_bad_header();
    clear_log();
    put_word(32'hFFFF_FCFF, 1);
    idle(3);
    total++;
    if (err_cnt != 1 || wrq.size() != 0) begin
      bad++; $display("[TB] FAIL bad_two_bits got err=%0d writes=%0d want err=1 writes=0", err_cnt, wrq.size());
    end
    put_word(32'hFFFF_EFFF, 1);
    idle(3);
    total++;
    if (err_cnt != 2 || wrq.size() != 0) begin
      bad++; $display("[TB] FAIL bad_ch4 got err=%0d writes=%0d want err=2 writes=0", err_cnt, wrq.size());
    end
    put_word(32'hFFFF_FDFF, 0);
    for (int i = 0; i < DCR; i++) put_word(32'h1111_0000 + 32'(i), 0);
    idle(4);
    total++;
    if (wrq.size() != DCR || err_cnt != 2) begin
      bad++; $display("[TB] FAIL bad_recover_count got writes=%0d err=%0d want writes=%0d err=2",
                      wrq.size(), err_cnt, DCR);
    end
    for (int i = 0; i < wrq.size() && i < DCR; i++) begin
      total++;
      if (wrq[i] !== wr_t'{4'b0010, 1'b0, AW'(i), 32'h1111_0000 + 32'(i), (i == DCR - 1)}) begin
        bad++; $display("[TB] FAIL bad_recover_write%0d got %h want %h", i, wrq[i],
                        wr_t'{4'b0010, 1'b0, AW'(i), 32'h1111_0000 + 32'(i), (i == DCR - 1)});
      end
    end
  endtask

  task automatic test_timeout();
    int last_cyc;
    int waited;
    clear_log();
    put_word(32'hFFFF_FBFF, 1);
    put_word(32'h2222_0000, 1);
    put_word(32'h2222_0001, 1);
    put_byte(8'h33);
    idle(1);
    put_byte(8'h44);
    last_cyc = cyc;
    waited = 0;
    while (err_cnt == 0 && waited < TMO + 50) begin
      idle(1);
      waited++;
    end
    total++;
    if (err_cnt != 1) begin
      bad++; $display("[TB] FAIL tmo_pulse got err=%0d want 1", err_cnt);
    end
    total++;
    if (err_cyc - last_cyc != TMO) begin
      bad++; $display("[TB] FAIL tmo_delay got %0d want %0d", err_cyc - last_cyc, TMO);
    end
    total++;
    if (wrq.size() != 2 || done_cnt != 0) begin
      bad++; $display("[TB] FAIL tmo_partial got writes=%0d done=%0d want writes=2 done=0", wrq.size(), done_cnt);
    end
    for (int i = 0; i < wrq.size() && i < 2; i++) begin
      total++;
      if (wrq[i] !== wr_t'{4'b0100, 1'b0, AW'(i), 32'h2222_0000 + 32'(i), 1'b0}) begin
        bad++; $display("[TB] FAIL tmo_write%0d got %h want %h", i, wrq[i],
                        wr_t'{4'b0100, 1'b0, AW'(i), 32'h2222_0000 + 32'(i), 1'b0});
      end
    end
    clear_log();
    put_word(32'hFFFF_FBFF, 0);
    for (int i = 0; i < DCR; i++) put_word(32'h5555_0000 + 32'(i), 0);
    idle(4);
    total++;
    if (wrq.size() != DCR || err_cnt != 0 || done_cnt != 1) begin
      bad++; $display("[TB] FAIL tmo_next got writes=%0d err=%0d done=%0d want %0d/0/1",
                      wrq.size(), err_cnt, done_cnt, DCR);
    end
    for (int i = 0; i < wrq.size() && i < DCR; i++) begin
      total++;
      if (wrq[i] !== wr_t'{4'b0100, 1'b0, AW'(i), 32'h5555_0000 + 32'(i), (i == DCR - 1)}) begin
        bad++; $display("[TB] FAIL tmo_next_write%0d got %h want %h", i, wrq[i],
                        wr_t'{4'b0100, 1'b0, AW'(i), 32'h5555_0000 + 32'(i), (i == DCR - 1)});
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    put_word(32'hFFFF_FEFF, 0);
    for (int i = 0; i < 5; i++) put_word(32'h7700_0010 + 32'(i), 0);
    put_byte(8'h99);
    put_byte(8'h88);
    rst = 1'b1;
    idle(1);
    total++;
    if ({wr_en, wr_dc_sel, wr_launch, wr_addr, wr_data, pkt_done, pkt_err} !== '0) begin
      bad++;
      $display("[TB] FAIL rst_mid_outputs got en=%b sel=%b l=%b a=%0d d=%h done=%b err=%b want all 0",
               wr_en, wr_dc_sel, wr_launch, wr_addr, wr_data, pkt_done, pkt_err);
    end
    rst = 1'b0;
    idle(2);
    total++;
    if (wrq.size() != 5 || done_cnt != 0) begin
      bad++; $display("[TB] FAIL rst_mid_partial got writes=%0d done=%0d want writes=5 done=0", wrq.size(), done_cnt);
    end
    clear_log();
    put_word(32'hFFFF_FEFF, 1);
    for (int i = 0; i < DCR; i++) put_word(32'h8800_0000 + 32'(i), 0);
    idle(4);
    total++;
    if (wrq.size() != DCR || err_cnt != 0) begin
      bad++; $display("[TB] FAIL rst_fresh_count got writes=%0d err=%0d want %0d/0", wrq.size(), err_cnt, DCR);
    end
    for (int i = 0; i < wrq.size() && i < DCR; i++) begin
      total++;
      if (wrq[i] !== wr_t'{4'b0001, 1'b0, AW'(i), 32'h8800_0000 + 32'(i), (i == DCR - 1)}) begin
        bad++; $display("[TB] FAIL rst_fresh_write%0d got %h want %h", i, wrq[i],
                        wr_t'{4'b0001, 1'b0, AW'(i), 32'h8800_0000 + 32'(i), (i == DCR - 1)});
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    put_word(32'hFFFF_FFFF, 0);
    for (int i = 0; i < LR; i++) put_word(32'h0BAD_F000 + 32'(i), 0);
    put_word(32'hFFFF_FDFF, 0);
    for (int i = 0; i < DCR; i++) put_word(32'h1234_5600 + 32'(i), 0);
    idle(4);
    total++;
    if (wrq.size() != LR + DCR || err_cnt != 0 || done_cnt != 2) begin
      bad++; $display("[TB] FAIL b2b_count got writes=%0d err=%0d done=%0d want %0d/0/2",
                      wrq.size(), err_cnt, done_cnt, LR + DCR);
    end
    for (int i = 0; i < wrq.size() && i < LR + DCR; i++) begin
      wr_t exp;
      if (i < LR) exp = '{4'b0000, 1'b1, AW'(i), 32'h0BAD_F000 + 32'(i), (i == LR - 1)};
      else        exp = '{4'b0010, 1'b0, AW'(i - LR), 32'h1234_5600 + 32'(i - LR), (i == LR + DCR - 1)};
      total++;
      if (wrq[i] !== exp) begin
        bad++; $display("[TB] FAIL b2b_write%0d got %h want %h", i, wrq[i], exp);
      end
    end
  endtask

  task automatic test_tmo_coincide();
    clear_log();
    put_word(32'hFFFF_FEFF, 0);
    put_byte(8'hDE);
    // Next byte lands on the exact edge where the timeout would fire
    repeat (TMO - 1) @(posedge clk);
    #1;
    put_byte(8'hAD);
    put_byte(8'hBE);
    put_byte(8'hEF);
    for (int i = 1; i < DCR; i++) put_word(32'h6600_0000 + 32'(i), 0);
    idle(4);
    total++;
    if (err_cnt != 0) begin
      bad++; $display("[TB] FAIL coincide_err got %0d want 0", err_cnt);
    end
    total++;
    if (wrq.size() != DCR || done_cnt != 1) begin
      bad++; $display("[TB] FAIL coincide_count got writes=%0d done=%0d want %0d/1", wrq.size(), done_cnt, DCR);
    end
    for (int i = 0; i < wrq.size() && i < DCR; i++) begin
      wr_t exp;
      exp = '{4'b0001, 1'b0, AW'(i), (i == 0) ? 32'hDEAD_BEEF : 32'h6600_0000 + 32'(i), (i == DCR - 1)};
      total++;
      if (wrq[i] !== exp) begin
        bad++; $display("[TB] FAIL coincide_write%0d got %h want %h", i, wrq[i], exp);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    err_cnt  = 0;
    err_cyc  = 0;
    done_cnt = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_dc_ch0();
    test_dc3_launch();
    test_bad_header();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_tmo_coincide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
